ssd1306_spi_sink: RTL and testbench

SPI mode-0 responder that models the SSD1306 panel end of the display link. It is used in simulation and on-FPGA loopback so the display controller can be checked without a real panel. It deserialises SCK/MOSI bytes gated by CS_n and qualified by DC, then decodes the addressing command subset. Data bytes go out through a framebuffer write port (1024 bytes, 8 pages × 128 columns).

---
 rtl/ssd1306_pkg.sv | 34 +++
 rtl/ssd1306_spi_sink_rx.sv | 85 ++++++++
 rtl/ssd1306_spi_sink.sv | 181 ++++++++++++++++++
 tb/tb_ssd1306_spi_sink.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ssd1306_pkg.sv
// Shared opcodes, addressing-mode encodings, panel geometry and decoder state type
// for the SSD1306 panel-side SPI model.
package ssd1306_pkg;

  localparam logic [7:0] CMD_MODE     = 8'h20;
  localparam logic [7:0] CMD_COLADDR  = 8'h21;
  localparam logic [7:0] CMD_PAGEADDR = 8'h22;
  localparam logic [7:0] CMD_DISP_OFF = 8'hAE;
  localparam logic [7:0] CMD_DISP_ON  = 8'hAF;

  localparam logic [1:0] MODE_HORIZ = 2'd0;
  localparam logic [1:0] MODE_VERT  = 2'd1;
  localparam logic [1:0] MODE_PAGE  = 2'd2;

  localparam int COLS   = 128;
  localparam int PAGES  = 8;
  localparam int COL_W  = $clog2(COLS);
  localparam int PAGE_W = $clog2(PAGES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARG1 = 2'd1,
    ST_ARG2 = 2'd2
  } dec_state_e;

  // Opcodes that take a single argument which this model swallows.
  function automatic logic is_one_arg(input logic [7:0] op);
    case (op)
      8'h81, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB: return 1'b1;
      default:                                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ssd1306_spi_sink_rx.sv
// SPI mode-0 byte receiver: input synchronisers, SCK rising-edge detect,
// MSB-first shift register and bit counter with CS_n framing.
module spi_slave_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_SPI_Clk,
  input  logic       i_SPI_MOSI,
  input  logic       i_SPI_CS_n,
  input  logic       i_DC,
  output logic [7:0] o_Byte,
  output logic       o_DC,
  output logic       o_DV
);

  logic [SYNC_STAGES-1:0] sck_sync_q, mosi_sync_q, cs_sync_q, dc_sync_q;
  logic                   sck_prev_q, cs_prev_q;
  logic [6:0]             shift_q, shift_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [7:0]             byte_q, byte_d;
  logic                   dc_q, dc_d, dv_q, dv_d;
  logic                   sck_s, mosi_s, cs_s, dc_s, shift_en, done;

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign dc_s   = dc_sync_q[SYNC_STAGES-1];

  // Looking at the previous CS_n too lets an 8th edge that coincides with
  // CS_n rising still complete its byte.
  assign shift_en = sck_s & ~sck_prev_q & (~cs_s | ~cs_prev_q);
  assign done     = shift_en & (cnt_q == 3'd7);

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    byte_d  = byte_q;
    dc_d    = dc_q;
    dv_d    = 1'b0;
    if (shift_en) begin
      shift_d = {shift_q[5:0], mosi_s};
      cnt_d   = cnt_q + 3'd1;
    end
    if (done) begin
      byte_d = {shift_q, mosi_s};
      dc_d   = dc_s;
      dv_d   = 1'b1;
    end
    if (cs_s) cnt_d = '0;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;
      dc_sync_q   <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b1;
      shift_q     <= '0;
      cnt_q       <= '0;
      byte_q      <= '0;
      dc_q        <= 1'b0;
      dv_q        <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], i_SPI_Clk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_SPI_MOSI};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], i_SPI_CS_n};
      dc_sync_q   <= {dc_sync_q[SYNC_STAGES-2:0], i_DC};
      sck_prev_q  <= sck_s;
      cs_prev_q   <= cs_s;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      byte_q      <= byte_d;
      dc_q        <= dc_d;
      dv_q        <= dv_d;
    end
  end

  assign o_Byte = byte_q;
  assign o_DC   = dc_q;
  assign o_DV   = dv_q;

endmodule

// File: rtl/ssd1306_spi_sink.sv
// SSD1306 panel-side model: command decoder for the addressing subset, GDDRAM
// column/page pointers and the framebuffer write port.
module ssd1306_spi_sink
  import ssd1306_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FB_ADDR_W   = 10
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_L,
  input  logic                 i_SPI_Clk,
  input  logic                 i_SPI_MOSI,
  input  logic                 i_SPI_CS_n,
  input  logic                 i_DC,
  output logic                 o_Wr_En,
  output logic [FB_ADDR_W-1:0] o_Wr_Addr,
  output logic [7:0]           o_Wr_Data,
  output logic                 o_Cmd_DV,
  output logic [7:0]           o_Cmd_Byte,
  output logic                 o_Display_On,
  output logic [1:0]           o_Mode
);

  logic [7:0] rx_byte;
  logic       rx_dc, rx_dv;

  spi_slave_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
    .i_Clk      (i_Clk),
    .i_Rst_L    (i_Rst_L),
    .i_SPI_Clk  (i_SPI_Clk),
    .i_SPI_MOSI (i_SPI_MOSI),
    .i_SPI_CS_n (i_SPI_CS_n),
    .i_DC       (i_DC),
    .o_Byte     (rx_byte),
    .o_DC       (rx_dc),
    .o_DV       (rx_dv)
  );

  dec_state_e           state_q, state_d;
  logic [7:0]           cmd_q, cmd_d;
  logic [COL_W-1:0]     arg1_q, arg1_d;
  logic [COL_W-1:0]     col_q, col_d, col_start_q, col_start_d, col_end_q, col_end_d;
  logic [PAGE_W-1:0]    page_q, page_d, page_start_q, page_start_d, page_end_q, page_end_d;
  logic [1:0]           mode_q, mode_d;
  logic                 disp_q, disp_d;
  logic                 wr_en_q, wr_en_d, cmd_dv_q, cmd_dv_d;
  logic [FB_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]           wr_data_q, wr_data_d, cmd_byte_q, cmd_byte_d;

  logic                 col_wrap, page_wrap;
  logic [COL_W-1:0]     col_inc, col_rng;
  logic [PAGE_W-1:0]    page_rng;

  assign col_wrap  = (col_q == col_end_q);
  assign page_wrap = (page_q == page_end_q);
  assign col_inc   = col_q + 1'b1;
  assign col_rng   = col_wrap ? col_start_q : col_inc;
  assign page_rng  = page_wrap ? page_start_q : page_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    arg1_d       = arg1_q;
    col_d        = col_q;
    col_start_d  = col_start_q;
    col_end_d    = col_end_q;
    page_d       = page_q;
    page_start_d = page_start_q;
    page_end_d   = page_end_q;
    mode_d       = mode_q;
    disp_d       = disp_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    cmd_dv_d     = 1'b0;
    cmd_byte_d   = cmd_byte_q;
    if (rx_dv && rx_dc) begin
      // Data aborts any half-received command; range args only commit on completion.
      state_d   = ST_IDLE;
      wr_en_d   = 1'b1;
      wr_addr_d = FB_ADDR_W'({page_q, col_q});
      wr_data_d = rx_byte;
      case (mode_q)
        MODE_HORIZ: begin
          col_d = col_rng;
          if (col_wrap) page_d = page_rng;
        end
        MODE_VERT: begin
          page_d = page_rng;
          if (page_wrap) col_d = col_rng;
        end
        default: col_d = col_inc;
      endcase
    end else if (rx_dv) begin
      cmd_dv_d   = 1'b1;
      cmd_byte_d = rx_byte;
      case (state_q)
        ST_IDLE: begin
          cmd_d = rx_byte;
          if (rx_byte == CMD_MODE || rx_byte == CMD_COLADDR ||
              rx_byte == CMD_PAGEADDR || is_one_arg(rx_byte))
            state_d = ST_ARG1;
          else if (rx_byte == CMD_DISP_OFF)     disp_d = 1'b0;
          else if (rx_byte == CMD_DISP_ON)      disp_d = 1'b1;
          else if (rx_byte[7:3] == 5'b10110)    page_d = rx_byte[2:0];
          else if (rx_byte[7:4] == 4'h0)        col_d[3:0] = rx_byte[3:0];
          else if (rx_byte[7:3] == 5'b00010)    col_d[6:4] = rx_byte[2:0];
        end
        ST_ARG1: begin
          arg1_d  = rx_byte[6:0];
          state_d = ST_IDLE;
          if (cmd_q == CMD_MODE) begin
            if (rx_byte[1:0] != 2'd3) mode_d = rx_byte[1:0];
          end else if (cmd_q == CMD_COLADDR || cmd_q == CMD_PAGEADDR) begin
            state_d = ST_ARG2;
          end
        end
        ST_ARG2: begin
          state_d = ST_IDLE;
          if (cmd_q == CMD_COLADDR) begin
            col_start_d = arg1_q;
            col_end_d   = rx_byte[6:0];
            col_d       = arg1_q;
          end else begin
            page_start_d = arg1_q[2:0];
            page_end_d   = rx_byte[2:0];
            page_d       = arg1_q[2:0];
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q      <= ST_IDLE;
      cmd_q        <= '0;
      arg1_q       <= '0;
      col_q        <= '0;
      col_start_q  <= '0;
      col_end_q    <= COL_W'(COLS - 1);
      page_q       <= '0;
      page_start_q <= '0;
      page_end_q   <= PAGE_W'(PAGES - 1);
      mode_q       <= MODE_PAGE;
      disp_q       <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      cmd_dv_q     <= 1'b0;
      cmd_byte_q   <= '0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      arg1_q       <= arg1_d;
      col_q        <= col_d;
      col_start_q  <= col_start_d;
      col_end_q    <= col_end_d;
      page_q       <= page_d;
      page_start_q <= page_start_d;
      page_end_q   <= page_end_d;
      mode_q       <= mode_d;
      disp_q       <= disp_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      cmd_dv_q     <= cmd_dv_d;
      cmd_byte_q   <= cmd_byte_d;
    end
  end

  assign o_Wr_En      = wr_en_q;
  assign o_Wr_Addr    = wr_addr_q;
  assign o_Wr_Data    = wr_data_q;
  assign o_Cmd_DV     = cmd_dv_q;
  assign o_Cmd_Byte   = cmd_byte_q;
  assign o_Display_On = disp_q;
  assign o_Mode       = mode_q;

endmodule

// File: tb/tb_ssd1306_spi_sink.sv
// Bench for ssd1306_spi_sink: a transaction-level panel model predicts writes and
// command bytes, a per-cycle compare process checks them, plus literal address lists.
module tb_ssd1306_spi_sink;
  localparam int SYNC = 2;
  localparam int AW   = 10;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          sck = 1'b0, mosi = 1'b0, cs_n = 1'b1, dc = 1'b0;
  logic          wr_en, cmd_dv, disp;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data, cmd_byte;
  logic [1:0]    mode;

  always #5 clk = ~clk;

  ssd1306_spi_sink #(.SYNC_STAGES(SYNC), .FB_ADDR_W(AW)) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_SPI_Clk(sck), .i_SPI_MOSI(mosi),
    .i_SPI_CS_n(cs_n), .i_DC(dc), .o_Wr_En(wr_en), .o_Wr_Addr(wr_addr),
    .o_Wr_Data(wr_data), .o_Cmd_DV(cmd_dv), .o_Cmd_Byte(cmd_byte),
    .o_Display_On(disp), .o_Mode(mode)
  );

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- panel model ----------------
  int m_col, m_page, m_cs, m_ce, m_ps, m_pe, m_mode, m_disp;
  int pend_op;
  int pend_args[$];
  int exp_addr[$], exp_data[$], exp_cmd[$];
  int wr_log[$];
  int cmd_cnt = 0;

  task automatic model_reset();
    m_col = 0; m_page = 0; m_cs = 0; m_ce = 127; m_ps = 0; m_pe = 7;
    m_mode = 2; m_disp = 0; pend_op = -1; pend_args.delete();
    exp_addr.delete(); exp_data.delete(); exp_cmd.delete();
  endtask

  function automatic int nargs(input int op);
    case (op)
      'h20: return 1;
      'h21, 'h22: return 2;
      'h81, 'h8D, 'hA8, 'hD3, 'hD5, 'hD9, 'hDA, 'hDB: return 1;
      default: return 0;
    endcase
  endfunction

  task automatic model_byte(input int b, input bit d);
    if (d) begin
      pend_op = -1; pend_args.delete();
      exp_addr.push_back(m_page * 128 + m_col);
      exp_data.push_back(b);
      if (m_mode == 0) begin
        if (m_col == m_ce) begin
          m_col = m_cs;
          m_page = (m_page == m_pe) ? m_ps : (m_page + 1) % 8;
        end else m_col = (m_col + 1) % 128;
      end else if (m_mode == 1) begin
        if (m_page == m_pe) begin
          m_page = m_ps;
          m_col = (m_col == m_ce) ? m_cs : (m_col + 1) % 128;
        end else m_page = (m_page + 1) % 8;
      end else m_col = (m_col + 1) % 128;
    end else begin
      exp_cmd.push_back(b);
      if (pend_op < 0) begin
        if (nargs(b) > 0) pend_op = b;
        else if (b == 'hAE) m_disp = 0;
        else if (b == 'hAF) m_disp = 1;
        else if (b >= 'hB0 && b <= 'hB7) m_page = b - 'hB0;
        else if (b <= 'h0F) m_col = (m_col / 16) * 16 + b;
        else if (b >= 'h10 && b <= 'h17) m_col = (m_col % 16) + (b - 'h10) * 16;
      end else begin
        pend_args.push_back(b);
        if (pend_args.size() == nargs(pend_op)) begin
          if (pend_op == 'h20 && (pend_args[0] % 4) != 3) m_mode = pend_args[0] % 4;
          if (pend_op == 'h21) begin
            m_cs = pend_args[0] % 128; m_ce = pend_args[1] % 128; m_col = m_cs;
          end
          if (pend_op == 'h22) begin
            m_ps = pend_args[0] % 8; m_pe = pend_args[1] % 8; m_page = m_ps;
          end
          pend_op = -1; pend_args.delete();
        end
      end
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        wr_log.push_back(int'(wr_addr));
        if (exp_addr.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          chk("wr_addr", int'(wr_addr), exp_addr.pop_front());
          chk("wr_data", int'(wr_data), exp_data.pop_front());
        end
      end
      if (cmd_dv) begin
        cmd_cnt++;
        if (exp_cmd.size() == 0) chk("unexpected_cmd", 1, 0);
        else chk("cmd_byte", int'(cmd_byte), exp_cmd.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic half();
    repeat (4) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input bit d, input int nbits = 8);
    int lat;
    lat = 0;
    if (nbits == 8) model_byte(int'(b), d);
    @(negedge clk);
    dc = d; cs_n = 1'b0;
    half();
    for (int i = 0; i < nbits; i++) begin
      mosi = b[7-i];
      half();
      sck = 1'b1;
      if (i == 7) begin
        for (int k = 1; k <= 4; k++) begin
          @(posedge clk); #1;
          if ((wr_en || cmd_dv) && lat == 0) lat = k;
        end
        @(negedge clk);
      end else half();
      sck = 1'b0;
    end
    half();
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
    if (nbits == 8) begin
      chk("latency", lat, SYNC + 2);
      chk("display_on", int'(disp), m_disp);
      chk("mode", int'(mode), m_mode);
    end
  endtask

  task automatic check_log(input string nm, input int exp[$]);
    chk($sformatf("%s_count", nm), wr_log.size(), exp.size());
    for (int i = 0; i < exp.size() && i < wr_log.size(); i++)
      chk($sformatf("%s_addr%0d", nm, i), wr_log[i], exp[i]);
    wr_log.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int q[$];
    int c0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_cmd_dv", int'(cmd_dv), 0);
    chk("rst_disp", int'(disp), 0);
    chk("rst_mode", int'(mode), 2);
    chk("rst_wr_addr", int'(wr_addr), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    send(8'hAA, 1); send(8'h55, 1);
    q = {0, 1}; check_log("defaults", q);

    send(8'h20, 0); send(8'h00, 0);
    send(8'h21, 0); send(8'h7E, 0); send(8'h7F, 0);
    send(8'h22, 0); send(8'h06, 0); send(8'h07, 0);
    for (int i = 0; i < 5; i++) send(8'(8'h10 + i), 1);
    q = {894, 895, 1022, 1023, 894}; check_log("horiz", q);

    send(8'h20, 0); send(8'h01, 0);
    send(8'h21, 0); send(8'h00, 0); send(8'h7F, 0);
    send(8'h22, 0); send(8'h00, 0); send(8'h07, 0);
    wr_log.delete();
    for (int i = 0; i < 9; i++) send(8'(8'hC0 + i), 1);
    q = {0, 128, 256, 384, 512, 640, 768, 896, 1}; check_log("vert", q);

    send(8'h20, 0); send(8'h02, 0);
    send(8'hB3, 0); send(8'h05, 0); send(8'h12, 0);
    wr_log.delete();
    send(8'h3C, 1); send(8'h3D, 1);
    q = {421, 422}; check_log("page", q);
    send(8'h0F, 0); send(8'h17, 0);
    send(8'h01, 1); send(8'h02, 1);
    q = {511, 384}; check_log("page_wrap", q);

    send(8'h21, 0); send(8'h10, 0); send(8'h77, 1);
    q = {385}; check_log("abort", q);
    send(8'hAF, 0);
    chk("abort_then_disp_on", int'(disp), 1);

    send(8'hA5, 1, 4);
    chk("partial_no_write", wr_log.size(), 0);
    send(8'hAE, 0);
    chk("after_partial_disp_off", int'(disp), 0);

    send(8'h20, 0); send(8'h03, 0);
    chk("mode3_ignored", int'(mode), 2);

    c0 = cmd_cnt;
    send(8'h81, 0); send(8'hAF, 0);
    chk("split_cmd_dv_count", cmd_cnt - c0, 2);
    chk("split_arg_discarded", int'(disp), 0);

    send(8'hAF, 0);
    @(negedge clk);
    dc = 1'b0; cs_n = 1'b0;
    half();
    for (int i = 0; i < 3; i++) begin
      mosi = 1'b1; half(); sck = 1'b1; half(); sck = 1'b0;
    end
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_disp", int'(disp), 0);
    chk("async_rst_mode", int'(mode), 2);
    chk("async_rst_wr_en", int'(wr_en), 0);
    chk("async_rst_cmd_byte", int'(cmd_byte), 0);
    model_reset();
    repeat (3) @(negedge clk);
    cs_n = 1'b1; sck = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    send(8'hAF, 0);
    chk("post_rst_disp_on", int'(disp), 1);

    repeat (10) @(negedge clk);
    chk("pending_writes", exp_addr.size(), 0);
    chk("pending_cmds", exp_cmd.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
